// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: state width, round count, FSM encoding and
// the small GF(2^8) / byte-permutation helpers used by the round datapath.
package aes_pkg;

    localparam int unsigned NB_STATE        = 128;
    localparam int unsigned N_ROUNDS_AES128 = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r rotates left by r columns; byte k = r + 4c sits at [127-8k -: 8].
    function automatic logic [NB_STATE-1:0] shift_rows(input logic [NB_STATE-1:0] s);
        logic [NB_STATE-1:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[NB_STATE-1-8*(r+4*c) -: 8] = s[NB_STATE-1-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/mix_columns_block.sv
// Combinational AES MixColumns across the four state columns.
module mix_columns_block
    import aes_pkg::*;
(
    input  logic [NB_STATE-1:0] i_state,
    output logic [NB_STATE-1:0] o_state
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;

        assign a0 = i_state[NB_STATE-1-32*c      -: 8];
        assign a1 = i_state[NB_STATE-1-32*c -  8 -: 8];
        assign a2 = i_state[NB_STATE-1-32*c - 16 -: 8];
        assign a3 = i_state[NB_STATE-1-32*c - 24 -: 8];

        // Rows {02 03 01 01} rotated; 03*a is xtime(a) ^ a.
        assign o_state[NB_STATE-1-32*c -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    end

endmodule

// File: rtl/subbytes_block.sv
// Byte-wise AES S-box over the full 128-bit state, with an optional output
// register stage selected by CREATE_OUTPUT_REG.
module subbytes_block
    import aes_pkg::*;
#(
    parameter bit CREATE_OUTPUT_REG = 1'b1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [NB_STATE-1:0] i_state,
    output logic                o_valid,
    output logic [NB_STATE-1:0] o_state
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [NB_STATE-1:0] sub_state;

    for (genvar k = 0; k < 16; k++) begin : g_byte
        assign sub_state[NB_STATE-1-8*k -: 8] = SBOX[i_state[NB_STATE-1-8*k -: 8]];
    end

    if (CREATE_OUTPUT_REG) begin : g_reg
        logic                valid_q;
        logic [NB_STATE-1:0] state_q;

        always_ff @(posedge i_clock or negedge i_reset) begin
            if (!i_reset) begin
                valid_q <= 1'b0;
                state_q <= '0;
            end else begin
                valid_q <= i_valid;
                if (i_valid) begin
                    state_q <= sub_state;
                end
            end
        end

        assign o_valid = valid_q;
        assign o_state = state_q;
    end else begin : g_comb
        // Clock and reset have no load when the stage is purely combinational.
        logic unused_clk_rst;
        assign unused_clk_rst = i_clock ^ i_reset;
        assign o_valid        = i_valid;
        assign o_state        = sub_state;
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one block in flight, one round per cycle,
// round keys supplied flat by the upstream key schedule.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned NB_BYTE  = 8,   // only 8 is a valid configuration
    parameter int unsigned N_BYTES  = 16,
    parameter int unsigned N_ROUNDS = N_ROUNDS_AES128
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_valid,
    input  logic [N_BYTES*NB_BYTE-1:0]         i_plaintext,
    input  logic [(N_ROUNDS+1)*NB_STATE-1:0]   i_round_keys,
    output logic                               o_ready,
    output logic                               o_valid,
    output logic [N_BYTES*NB_BYTE-1:0]         o_ciphertext
);

    localparam int unsigned CNT_W = $clog2(N_ROUNDS + 1);

    fsm_t                fsm_q, fsm_d;
    logic [CNT_W-1:0]    round_q, round_d;
    logic [NB_STATE-1:0] state_q, state_d;
    logic [NB_STATE-1:0] ct_q, ct_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;

    logic                run;
    logic                sb_valid;
    logic [NB_STATE-1:0] sb_state;
    logic [NB_STATE-1:0] sr_state;
    logic [NB_STATE-1:0] mc_state;
    logic [NB_STATE-1:0] rk0;
    logic [NB_STATE-1:0] rk;

    assign run = (fsm_q == RUN);

    subbytes_block #(
        .CREATE_OUTPUT_REG(1'b0)
    ) u_subbytes (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_valid (run),
        .i_state (state_q),
        .o_valid (sb_valid),
        .o_state (sb_state)
    );

    assign sr_state = shift_rows(sb_state);

    mix_columns_block u_mix_columns (
        .i_state (sr_state),
        .o_state (mc_state)
    );

    // Whitening key for the accept cycle; per-round key muxed by round_q.
    assign rk0 = i_round_keys[NB_STATE-1:0];

    always_comb begin
        rk = '0;
        for (int r = 0; r <= int'(N_ROUNDS); r++) begin
            if (round_q == CNT_W'(r)) begin
                rk = i_round_keys[r*NB_STATE +: NB_STATE];
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            fsm_q   <= IDLE;
            round_q <= '0;
            state_q <= '0;
            ct_q    <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
            ct_q    <= ct_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        state_d = state_q;
        ct_d    = ct_q;
        valid_d = 1'b0;

        unique case (fsm_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = NB_STATE'(i_plaintext) ^ rk0;
                    round_d = CNT_W'(1);
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                if (sb_valid) begin
                    // Final round skips MixColumns and publishes the block.
                    if (round_q == CNT_W'(N_ROUNDS)) begin
                        ct_d    = sr_state ^ rk;
                        valid_d = 1'b1;
                        round_d = '0;
                        fsm_d   = IDLE;
                    end else begin
                        state_d = mc_state ^ rk;
                        round_d = round_q + CNT_W'(1);
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase

        ready_d = (fsm_d == IDLE);
    end

    assign o_ready      = ready_q;
    assign o_valid      = valid_q;
    assign o_ciphertext = (N_BYTES*NB_BYTE)'(ct_q);

endmodule
